// File: rtl/id_pkg.sv
// Shared constants and types for the instruction-decode stage.
package id_pkg;

  localparam int DW_DEFAULT = 32;
  localparam int AW_DEFAULT = 5;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // Control bundle carried from decode into ID/EX; all-zero is a bubble.
  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic [1:0] alu_op;
  } ctrl_t;

endpackage

// File: rtl/id_stage_reg_file.sv
// Register file: two combinational read ports with writeback bypass, one
// write port, register 0 hard-wired to zero.
module reg_file
  import id_pkg::*;
#(
  parameter int DW = DW_DEFAULT,
  parameter int AW = AW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr1,
  input  logic [AW-1:0] raddr2,
  output logic [DW-1:0] rdata1,
  output logic [DW-1:0] rdata2
);

  localparam int NREG = 2 ** AW;

  logic [DW-1:0] regs [NREG];

  // Storage: cleared on reset; writes to register 0 are dropped so it always reads 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (we && (waddr != '0)) begin
      regs[waddr] <= wdata;
    end
  end

  // Reads see a same-cycle writeback so decode never picks up a stale value.
  always_comb begin
    rdata1 = regs[raddr1];
    rdata2 = regs[raddr2];
    if (we && (waddr == raddr1) && (raddr1 != '0)) rdata1 = wdata;
    if (we && (waddr == raddr2) && (raddr2 != '0)) rdata2 = wdata;
  end

endmodule

// File: rtl/id_stage.sv
// Instruction decode: control decode, register read, sign extension, early
// branch resolution, hazard detection and the ID/EX pipeline register.
module id_stage
  import id_pkg::*;
#(
  parameter int DW = DW_DEFAULT,
  parameter int AW = AW_DEFAULT
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic [DW-1:0] i_next_pc,
  input  logic [DW-1:0] i_instr,
  input  logic          i_wb_en,
  input  logic [AW-1:0] i_wb_addr,
  input  logic [DW-1:0] i_wb_data,
  input  logic          i_exmem_reg_write,
  input  logic [AW-1:0] i_exmem_rd,
  output logic          o_PCSrc,
  output logic [DW-1:0] o_branch_addr,
  output logic          o_stall,
  output logic          o_flush,
  output logic [DW-1:0] o_pc4,
  output logic [DW-1:0] o_rs_data,
  output logic [DW-1:0] o_rt_data,
  output logic [DW-1:0] o_imm,
  output logic [AW-1:0] o_rs,
  output logic [AW-1:0] o_rt,
  output logic [AW-1:0] o_rd,
  output logic [1:0]    o_alu_op,
  output logic [5:0]    o_funct,
  output logic          o_reg_dst,
  output logic          o_alu_src,
  output logic          o_mem_read,
  output logic          o_mem_write,
  output logic          o_mem_to_reg,
  output logic          o_reg_write
);

  // Instruction fields
  logic [5:0]    opcode;
  logic [AW-1:0] rs, rt, rd;
  logic [5:0]    funct;
  logic [DW-1:0] imm;

  assign opcode = i_instr[31:26];
  assign rs     = i_instr[25:21];
  assign rt     = i_instr[20:16];
  assign rd     = i_instr[15:11];
  assign funct  = i_instr[5:0];
  assign imm    = {{(DW-16){i_instr[15]}}, i_instr[15:0]};

  logic [DW-1:0] rs_data, rt_data;

  reg_file #(.DW(DW), .AW(AW)) u_reg_file (
    .clk    (i_clk),
    .rst    (i_rst),
    .we     (i_wb_en),
    .waddr  (i_wb_addr),
    .wdata  (i_wb_data),
    .raddr1 (rs),
    .raddr2 (rt),
    .rdata1 (rs_data),
    .rdata2 (rt_data)
  );

  // ID/EX pipeline register contents
  ctrl_t         ctrl_reg, ctrl_dec, ctrl_next;
  logic [DW-1:0] pc4_reg, rs_data_reg, rt_data_reg, imm_reg;
  logic [AW-1:0] rs_reg, rt_reg, rd_reg;
  logic [5:0]    funct_reg;

  logic is_beq, rt_is_src;

  // Main control decode; unknown opcodes fall through as an all-zero bubble.
  always_comb begin
    ctrl_dec  = '0;
    is_beq    = 1'b0;
    rt_is_src = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        ctrl_dec.reg_dst   = 1'b1;
        ctrl_dec.reg_write = 1'b1;
        ctrl_dec.alu_op    = ALUOP_FUNCT;
        rt_is_src          = 1'b1;
      end
      OP_LW: begin
        ctrl_dec.alu_src    = 1'b1;
        ctrl_dec.mem_read   = 1'b1;
        ctrl_dec.mem_to_reg = 1'b1;
        ctrl_dec.reg_write  = 1'b1;
        ctrl_dec.alu_op     = ALUOP_ADD;
      end
      OP_SW: begin
        ctrl_dec.alu_src   = 1'b1;
        ctrl_dec.mem_write = 1'b1;
        ctrl_dec.alu_op    = ALUOP_ADD;
        rt_is_src          = 1'b1;
      end
      OP_BEQ: begin
        ctrl_dec.alu_op = ALUOP_SUB;
        is_beq          = 1'b1;
        rt_is_src       = 1'b1;
      end
      OP_ADDI: begin
        ctrl_dec.alu_src   = 1'b1;
        ctrl_dec.reg_write = 1'b1;
        ctrl_dec.alu_op    = ALUOP_ADD;
      end
      default: ;
    endcase
  end

  logic [AW-1:0] ex_dest;
  logic          load_use, branch_haz, stall, take_branch;

  // Hazards: a load feeding the next instruction, or a beq whose operands
  // are still being produced one or two stages ahead (branch compares in ID).
  always_comb begin
    ex_dest  = ctrl_reg.reg_dst ? rd_reg : rt_reg;
    load_use = ctrl_reg.mem_read && (rt_reg != '0) &&
               ((rt_reg == rs) || (rt_is_src && (rt_reg == rt)));
    branch_haz = is_beq &&
      ((ctrl_reg.reg_write && (ex_dest != '0) && ((ex_dest == rs) || (ex_dest == rt))) ||
       (i_exmem_reg_write && (i_exmem_rd != '0) &&
        ((i_exmem_rd == rs) || (i_exmem_rd == rt))));
    stall       = !i_rst && (load_use || branch_haz);
    take_branch = !i_rst && is_beq && !stall && (rs_data == rt_data);
    // Branches are fully resolved here, so a beq never proceeds as real work.
    ctrl_next   = (stall || is_beq) ? ctrl_t'('0) : ctrl_dec;
  end

  assign o_stall       = stall;
  assign o_PCSrc       = take_branch;
  assign o_flush       = take_branch;
  assign o_branch_addr = i_next_pc + {imm[DW-3:0], 2'b00};

  // ID/EX register: loads every cycle; data fields follow decode even for bubbles.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ctrl_reg    <= '0;
      pc4_reg     <= '0;
      rs_data_reg <= '0;
      rt_data_reg <= '0;
      imm_reg     <= '0;
      rs_reg      <= '0;
      rt_reg      <= '0;
      rd_reg      <= '0;
      funct_reg   <= '0;
    end else begin
      ctrl_reg    <= ctrl_next;
      pc4_reg     <= i_next_pc;
      rs_data_reg <= rs_data;
      rt_data_reg <= rt_data;
      imm_reg     <= imm;
      rs_reg      <= rs;
      rt_reg      <= rt;
      rd_reg      <= rd;
      funct_reg   <= funct;
    end
  end

  assign o_pc4        = pc4_reg;
  assign o_rs_data    = rs_data_reg;
  assign o_rt_data    = rt_data_reg;
  assign o_imm        = imm_reg;
  assign o_rs         = rs_reg;
  assign o_rt         = rt_reg;
  assign o_rd         = rd_reg;
  assign o_funct      = funct_reg;
  assign o_alu_op     = ctrl_reg.alu_op;
  assign o_reg_dst    = ctrl_reg.reg_dst;
  assign o_alu_src    = ctrl_reg.alu_src;
  assign o_mem_read   = ctrl_reg.mem_read;
  assign o_mem_write  = ctrl_reg.mem_write;
  assign o_mem_to_reg = ctrl_reg.mem_to_reg;
  assign o_reg_write  = ctrl_reg.reg_write;

endmodule

// File: tb/tb_id_stage.sv
// Directed vector bench for id_stage: table of decode cases plus an
// asynchronous-reset-during-stall sequence.
module tb_id_stage;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [31:0] i_next_pc, i_instr, i_wb_data;
  logic        i_wb_en, i_exmem_reg_write;
  logic [4:0]  i_wb_addr, i_exmem_rd;
  logic        o_PCSrc, o_stall, o_flush;
  logic [31:0] o_branch_addr, o_pc4, o_rs_data, o_rt_data, o_imm;
  logic [4:0]  o_rs, o_rt, o_rd;
  logic [1:0]  o_alu_op;
  logic [5:0]  o_funct;
  logic        o_reg_dst, o_alu_src, o_mem_read, o_mem_write, o_mem_to_reg, o_reg_write;

  id_stage dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_next_pc(i_next_pc), .i_instr(i_instr),
    .i_wb_en(i_wb_en), .i_wb_addr(i_wb_addr), .i_wb_data(i_wb_data),
    .i_exmem_reg_write(i_exmem_reg_write), .i_exmem_rd(i_exmem_rd),
    .o_PCSrc(o_PCSrc), .o_branch_addr(o_branch_addr), .o_stall(o_stall), .o_flush(o_flush),
    .o_pc4(o_pc4), .o_rs_data(o_rs_data), .o_rt_data(o_rt_data), .o_imm(o_imm),
    .o_rs(o_rs), .o_rt(o_rt), .o_rd(o_rd), .o_alu_op(o_alu_op), .o_funct(o_funct),
    .o_reg_dst(o_reg_dst), .o_alu_src(o_alu_src), .o_mem_read(o_mem_read),
    .o_mem_write(o_mem_write), .o_mem_to_reg(o_mem_to_reg), .o_reg_write(o_reg_write)
  );

  always #5 i_clk = ~i_clk;

  // Control byte: {reg_dst, alu_src, mem_read, mem_write, mem_to_reg, reg_write, alu_op}
  localparam logic [7:0] C_NONE = 8'b0_0_0_0_0_0_00;
  localparam logic [7:0] C_R    = 8'b1_0_0_0_0_1_10;
  localparam logic [7:0] C_LW   = 8'b0_1_1_0_1_1_00;
  localparam logic [7:0] C_SW   = 8'b0_1_0_1_0_0_00;
  localparam logic [7:0] C_ADDI = 8'b0_1_0_0_0_1_00;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        xm_we;
    logic [4:0]  xm_rd;
    logic        stall, pcsrc, flush, chk_ba;
    logic [31:0] ba;
    logic [7:0]  ctrl;
    logic [31:0] rs_data, rt_data, imm;
  } vec_t;

  vec_t vq[$];
  int   errors = 0;
  int   checks = 0;

  function automatic logic [31:0] enc_r(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd, logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] enc_i(logic [5:0] op, logic [4:0] rs, logic [4:0] rt, logic [15:0] im);
    return {op, rs, rt, im};
  endfunction

  function automatic vec_t mk(logic [31:0] instr, logic [31:0] pc,
                              logic wb_en, logic [4:0] wb_addr, logic [31:0] wb_data,
                              logic xm_we, logic [4:0] xm_rd,
                              logic stall, logic pcsrc, logic flush, logic chk_ba, logic [31:0] ba,
                              logic [7:0] ctrl, logic [31:0] rs_data, logic [31:0] rt_data,
                              logic [31:0] imm);
    vec_t v;
    v.instr = instr; v.pc = pc; v.wb_en = wb_en; v.wb_addr = wb_addr; v.wb_data = wb_data;
    v.xm_we = xm_we; v.xm_rd = xm_rd; v.stall = stall; v.pcsrc = pcsrc; v.flush = flush;
    v.chk_ba = chk_ba; v.ba = ba; v.ctrl = ctrl; v.rs_data = rs_data; v.rt_data = rt_data;
    v.imm = imm;
    return v;
  endfunction

  task automatic chk(string name, int idx, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec=%0d actual=%h expected=%h", name, idx, act, exp);
    end
  endtask

  function automatic logic [7:0] ctrl_now();
    return {o_reg_dst, o_alu_src, o_mem_read, o_mem_write, o_mem_to_reg, o_reg_write, o_alu_op};
  endfunction

  task automatic drive(logic [31:0] instr, logic [31:0] pc, logic wb_en, logic [4:0] wb_addr,
                       logic [31:0] wb_data, logic xm_we, logic [4:0] xm_rd);
    i_instr = instr; i_next_pc = pc; i_wb_en = wb_en; i_wb_addr = wb_addr;
    i_wb_data = wb_data; i_exmem_reg_write = xm_we; i_exmem_rd = xm_rd;
  endtask

  logic [31:0] beq_back;

  initial begin
    beq_back = enc_i(6'h04, 5'd1, 5'd2, 16'hFFFF);
    // instr, pc, wb_en/addr/data, xm_we/rd, stall/pcsrc/flush, chk_ba, ba, ctrl, rs_data, rt_data, imm
    vq.push_back(mk(enc_r(5,0,3,6'h20), 32'h04, 1,5,32'h1234,     0,0, 0,0,0, 0,0,      C_R,    32'h1234, 0, 32'h1820));
    vq.push_back(mk(enc_r(0,0,1,6'h20), 32'h08, 1,0,32'hFFFFFFFF, 0,0, 0,0,0, 0,0,      C_R,    0, 0, 32'h0820));
    vq.push_back(mk(enc_i(6'h08,0,2,16'd7), 32'h0C, 1,1,32'd7,    0,0, 0,0,0, 0,0,      C_ADDI, 0, 0, 32'd7));
    vq.push_back(mk(beq_back, 32'h100, 1,2,32'd7,                  0,0, 1,0,0, 1,32'hFC, C_NONE, 7, 7, 32'hFFFFFFFF));
    vq.push_back(mk(beq_back, 32'h100, 0,0,0,                      0,0, 0,1,1, 1,32'hFC, C_NONE, 7, 7, 32'hFFFFFFFF));
    vq.push_back(mk(beq_back, 32'h100, 0,0,0,                      1,2, 1,0,0, 1,32'hFC, C_NONE, 7, 7, 32'hFFFFFFFF));
    vq.push_back(mk(beq_back, 32'h100, 0,0,0,                      0,0, 0,1,1, 1,32'hFC, C_NONE, 7, 7, 32'hFFFFFFFF));
    vq.push_back(mk(enc_i(6'h04,1,3,16'd4), 32'h200, 0,0,0,        0,0, 0,0,0, 1,32'h210, C_NONE, 7, 0, 32'd4));
    vq.push_back(mk(enc_i(6'h23,1,2,16'd4), 32'h204, 0,0,0,        0,0, 0,0,0, 0,0,      C_LW,   7, 7, 32'd4));
    vq.push_back(mk(enc_r(2,3,4,6'h20), 32'h208, 0,0,0,            0,0, 1,0,0, 0,0,      C_NONE, 7, 0, 32'h2020));
    vq.push_back(mk(enc_r(2,3,4,6'h20), 32'h208, 0,0,0,            0,0, 0,0,0, 0,0,      C_R,    7, 0, 32'h2020));
    vq.push_back(mk(enc_i(6'h23,0,6,16'd0), 32'h20C, 0,0,0,        0,0, 0,0,0, 0,0,      C_LW,   0, 0, 0));
    vq.push_back(mk(enc_i(6'h08,1,6,16'd1), 32'h210, 0,0,0,        0,0, 0,0,0, 0,0,      C_ADDI, 7, 0, 32'd1));
    vq.push_back(mk(enc_i(6'h23,1,0,16'd0), 32'h214, 0,0,0,        0,0, 0,0,0, 0,0,      C_LW,   7, 0, 0));
    vq.push_back(mk(enc_r(0,1,5,6'h20), 32'h218, 0,0,0,            0,0, 0,0,0, 0,0,      C_R,    0, 7, 32'h2820));
    vq.push_back(mk(32'hFC00_0000, 32'h21C, 0,0,0,                 0,0, 0,0,0, 0,0,      C_NONE, 0, 0, 0));
    vq.push_back(mk(enc_i(6'h23,0,3,16'd0), 32'h220, 0,0,0,        0,0, 0,0,0, 0,0,      C_LW,   0, 0, 0));
    vq.push_back(mk(enc_i(6'h2B,0,3,16'd4), 32'h224, 0,0,0,        0,0, 1,0,0, 0,0,      C_NONE, 0, 0, 32'd4));
    vq.push_back(mk(enc_i(6'h2B,0,3,16'd4), 32'h224, 0,0,0,        0,0, 0,0,0, 0,0,      C_SW,   0, 0, 32'd4));
    vq.push_back(mk(beq_back, 32'h100, 0,0,0,                      1,0, 0,1,1, 1,32'hFC, C_NONE, 7, 7, 32'hFFFFFFFF));

    // Reset with an equal-operand beq presented: nothing may fire while in reset.
    i_rst = 1'b1;
    drive(enc_i(6'h04,0,0,16'd0), 32'h0, 0,0,0, 1,5'd3);
    repeat (2) @(posedge i_clk);
    #1;
    chk("rst_stall",  -1, {31'd0, o_stall}, 0);
    chk("rst_pcsrc",  -1, {31'd0, o_PCSrc}, 0);
    chk("rst_flush",  -1, {31'd0, o_flush}, 0);
    chk("rst_ctrl",   -1, {24'd0, ctrl_now()}, 0);
    chk("rst_rsdata", -1, o_rs_data, 0);
    chk("rst_pc4",    -1, o_pc4, 0);
    $display("reset phase done");
    @(negedge i_clk);
    i_rst = 1'b0;

    foreach (vq[k]) begin
      if (k != 0) @(negedge i_clk);
      drive(vq[k].instr, vq[k].pc, vq[k].wb_en, vq[k].wb_addr, vq[k].wb_data,
            vq[k].xm_we, vq[k].xm_rd);
      #2;
      chk("stall", k, {31'd0, o_stall}, {31'd0, vq[k].stall});
      chk("pcsrc", k, {31'd0, o_PCSrc}, {31'd0, vq[k].pcsrc});
      chk("flush", k, {31'd0, o_flush}, {31'd0, vq[k].flush});
      if (vq[k].chk_ba) chk("branch_addr", k, o_branch_addr, vq[k].ba);
      @(posedge i_clk);
      #1;
      chk("ctrl",    k, {24'd0, ctrl_now()}, {24'd0, vq[k].ctrl});
      chk("rs_data", k, o_rs_data, vq[k].rs_data);
      chk("rt_data", k, o_rt_data, vq[k].rt_data);
      chk("imm",     k, o_imm, vq[k].imm);
      chk("pc4",     k, o_pc4, vq[k].pc);
      $display("vec %0d instr=%h pc=%h stall=%0b pcsrc=%0b ctrl=%b rs=%h rt=%h",
               k, vq[k].instr, vq[k].pc, o_stall, o_PCSrc, ctrl_now(), o_rs_data, o_rt_data);
    end

    // Asynchronous reset landing in the middle of a load-use stall.
    @(negedge i_clk);
    drive(enc_i(6'h23,1,2,16'd4), 32'h300, 0,0,0, 0,0);
    @(negedge i_clk);
    drive(enc_r(2,3,4,6'h20), 32'h304, 0,0,0, 0,0);
    #2;
    chk("ar_pre_stall", 100, {31'd0, o_stall}, 1);
    #1;
    i_rst = 1'b1;
    #1;
    chk("ar_stall",   100, {31'd0, o_stall}, 0);
    chk("ar_ctrl",    100, {24'd0, ctrl_now()}, 0);
    chk("ar_pc4",     100, o_pc4, 0);
    chk("ar_rsdata",  100, o_rs_data, 0);
    chk("ar_imm",     100, o_imm, 0);
    $display("async reset mid-stall: stall=%0b ctrl=%b", o_stall, ctrl_now());
    @(negedge i_clk);
    i_rst = 1'b0;
    drive(enc_r(1,2,1,6'h20), 32'h400, 0,0,0, 0,0);
    #2;
    chk("post_rst_stall", 101, {31'd0, o_stall}, 0);
    @(posedge i_clk);
    #1;
    chk("post_rst_rs", 101, o_rs_data, 0);
    chk("post_rst_rt", 101, o_rt_data, 0);
    chk("post_rst_ctrl", 101, {24'd0, ctrl_now()}, {24'd0, C_R});
    $display("post-reset decode: rs=%h rt=%h ctrl=%b", o_rs_data, o_rt_data, ctrl_now());

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- Instruction-decode stage of the 5-stage 32-bit MIPS-subset pipeline. Sits directly downstream of the fetch stage and consumes its IF/ID outputs (PC+4, instruction).
- Contains the register file, control decode, sign extension, early branch resolution, hazard detection and the ID/EX pipeline register.
- Drives the PC-source select and branch address back to fetch, plus stall and flush controls for the PC and the IF/ID register.

Parameters:
- DW, 32, datapath width.
- AW, 5, register-address width (2**AW registers).

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst  in  1  reset; one clock, reset is asynchronous and active-high.
- i_next_pc  in  32  PC+4 from IF/ID.
- i_instr  in  32  instruction from IF/ID.
- i_wb_en  in  1  writeback register-write enable.
- i_wb_addr  in  5  writeback destination.
- i_wb_data  in  32  writeback data.
- i_exmem_reg_write  in  1  EX/MEM stage will write a register.
- i_exmem_rd  in  5  EX/MEM destination.
- o_PCSrc  out  1  1 = fetch takes o_branch_addr.
- o_branch_addr  out  32  branch target.
- o_stall  out  1  freeze PC and IF/ID.
- o_flush  out  1  load NOP into IF/ID.
- o_pc4, o_rs_data, o_rt_data, o_imm  out  32 each  ID/EX data fields.
- o_rs, o_rt, o_rd  out  5 each  ID/EX register numbers.
- o_alu_op  out  2  ALU op class: 00 add, 01 sub, 10 use funct.
- o_funct  out  6  instruction funct field.
- o_reg_dst, o_alu_src, o_mem_read, o_mem_write, o_mem_to_reg, o_reg_write  out  1 each  ID/EX control.

Behaviour:
- Supported opcodes: R-type 0x00 (add, sub, and, or, slt via funct); lw 0x23; sw 0x2B; beq 0x04; addi 0x08. Any other opcode decodes as a bubble (all control 0).
- Register file:
  - 2**AW x DW registers.
  - Register 0 reads 0; writes to it are ignored.
  - Written on the rising edge when i_wb_en=1.
  - Read ports are combinational with write bypass: if i_wb_en and i_wb_addr==source and source!=0, the read returns i_wb_data in the same cycle.
- o_imm = sign-extended instr[15:0].
- ID/EX register:
  - 1-cycle latency; all o_* fields except o_PCSrc, o_branch_addr, o_stall and o_flush are registered.
  - Captures decode results every cycle.
  - When a bubble is inserted, all six control bits and o_alu_op are 0; data fields are don't-care but are still loaded.
- Load-use hazard: ID/EX mem_read=1, ID/EX rt!=0, and ID/EX rt equals the current rs or the current rt. The current rt counts as a source only for R-type, sw and beq.
- Branch hazard (beq only), either of:
  - ID/EX reg_write=1 and its destination (rd if reg_dst=1, else rt) is nonzero and matches rs or rt;
  - i_exmem_reg_write=1, i_exmem_rd!=0, and i_exmem_rd matches rs or rt.
- Stall (either hazard), combinational in the same cycle:
  - o_stall=1, o_PCSrc=0, o_flush=0;
  - a bubble is loaded into ID/EX;
  - the instruction is held and re-decoded next cycle.
- Branch resolution:
  - When beq is decoded with no stall and rs_data==rt_data (after WB bypass): o_PCSrc=1, o_flush=1, o_branch_addr = i_next_pc + (o_imm << 2), with 32-bit wrap.
  - The beq itself enters ID/EX as a bubble.
  - A not-taken beq also enters as a bubble, with o_PCSrc=0.
  - o_branch_addr is always driven with the computed value.
- Priority: stall > branch.
- Reset (asynchronous, active-high):
  - all registers and all ID/EX fields go to 0;
  - o_PCSrc, o_stall and o_flush are 0 while i_rst=1.
  - Reset asserted mid-stall clears the stall condition immediately, because ID/EX mem_read becomes 0.
- Instruction 0x00000000 (sll $0) decodes as an R-type write to $0, which is harmless.

Decomposition:
- Package id_pkg holds:
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI;
  - ALU-op constants ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT;
  - DW and AW defaults.
- One sub-module, reg_file: 2 read ports, 1 write port, asynchronous reset, write bypass. Decode, hazard logic and the ID/EX register remain in id_stage.

Test Plan:
- Reset then write $5=0x0000_1234 via WB; decode add $3,$5,$0 in the same cycle as the write -> next cycle o_rs_data=0x1234 (bypass), o_reg_write=1, o_reg_dst=1, o_alu_op=10.
- Write $0=0xFFFF_FFFF via WB, then decode add $1,$0,$0 -> o_rs_data=0, o_rt_data=0.
- lw $2,4($1) followed by add $4,$2,$3 -> o_stall=1 for exactly 1 cycle, a bubble in ID/EX (o_reg_write=0), then the add with correct controls.
- beq $1,$2,-1 at i_next_pc=0x100 with $1=$2=7, no hazard -> o_PCSrc=1, o_flush=1, o_branch_addr=0xFC; ID/EX controls all 0.
- beq $1,$2 with i_exmem_reg_write=1, i_exmem_rd=2 -> o_stall=1, o_PCSrc=0; next cycle with no hazard -> resolves.
- Assert i_rst asynchronously mid-cycle during a load-use stall -> all outputs 0 immediately and o_stall=0.
